// File: rtl/dram_rd_arbiter_pkg.sv
// Shared constants and helpers for the DRAM read arbiter and its tag FIFO.
package dram_rd_arbiter_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 18;
    localparam int NUM_REQ_DEF    = 3;
    localparam int MAX_OUT_DEF    = 4;

    // Requester identities as wired in lenet: activation loader, weight loader, bias loader.
    typedef enum logic [1:0] {
        REQ_IMG  = 2'd0,
        REQ_WGT  = 2'd1,
        REQ_BIAS = 2'd2
    } req_id_e;

    // Tag width needed to name one of numReq requesters.
    function automatic int tagWidth(input int numReq);
        return (numReq > 1) ? $clog2(numReq) : 1;
    endfunction

    // Counter width able to hold 0..maxOut inclusive.
    function automatic int cntWidth(input int maxOut);
        return $clog2(maxOut) + 1;
    endfunction

endpackage

// File: rtl/dram_rd_arbiter_tag_fifo.sv
// Tag FIFO remembering which requester issued each in-flight DRAM read.
// DEPTH must be a power of two so the pointers wrap naturally.
module dram_tag_fifo
    import dram_rd_arbiter_pkg::*;
#(
    parameter int DEPTH = MAX_OUT_DEF,
    parameter int WIDTH = tagWidth(NUM_REQ_DEF),
    parameter int CNT_W = cntWidth(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] pushTag_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] headTag_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             doPush;
    logic             doPop;

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign doPush    = push_i & ~full_o;
    assign doPop     = pop_i & ~empty_o;
    assign headTag_o = mem_q[rdPtr_q];
    assign count_o   = count_q;

    // Next pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (doPush) begin
            wrPtr_d = wrPtr_q + PTR_W'(1);
        end
        if (doPop) begin
            rdPtr_d = rdPtr_q + PTR_W'(1);
        end
        case ({doPush, doPop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers; reset empties the FIFO and discards any stored tags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Tag storage needs no reset because entries are only read while the count says they are valid.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= pushTag_i;
        end
    end

endmodule

// File: rtl/dram_rd_arbiter.sv
// Round-robin arbiter sharing the single DRAM read port among the lenet fetch engines.
// Reads return in issue order, so a tag FIFO routes each returning word to its requester.
module dram_rd_arbiter
    import dram_rd_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int NUM_REQ    = NUM_REQ_DEF,
    parameter int MAX_OUT    = MAX_OUT_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          dram_en_rd,
    output logic [ADDR_WIDTH-1:0]         dram_addr_rd,
    input  logic                          dram_valid,
    input  logic [DATA_WIDTH-1:0]         dram_data_rd,
    output logic                          busy,
    output logic                          err
);

    localparam int TAG_W = tagWidth(NUM_REQ);
    localparam int CNT_W = cntWidth(MAX_OUT);

    logic [TAG_W-1:0]      rrPtr_q, rrPtr_d;
    logic [TAG_W-1:0]      winner;
    logic [TAG_W-1:0]      cand;
    logic                  anyWin;
    logic [ADDR_WIDTH-1:0] winAddr;
    logic                  dramEn_q;
    logic [ADDR_WIDTH-1:0] dramAddr_q;
    logic [NUM_REQ-1:0]    rspValid_q;
    logic [DATA_WIDTH-1:0] rspData_q;
    logic                  err_q;
    logic                  fifoFull;
    logic                  fifoEmpty;
    logic [TAG_W-1:0]      headTag;
    logic [CNT_W-1:0]      outCount;
    logic                  doPop;

    // Eligibility uses the registered count only, so a pop in this cycle cannot free a slot until the next one.
    assign doPop = dram_valid & ~fifoEmpty;

    // Pick the first requester at or after the round-robin pointer; grant is combinational and suppressed in reset.
    always_comb begin
        anyWin  = 1'b0;
        winner  = '0;
        cand    = '0;
        gnt     = '0;
        winAddr = dramAddr_q;
        rrPtr_d = rrPtr_q;
        if (!rst && !fifoFull) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                cand = TAG_W'((int'(rrPtr_q) + j) % NUM_REQ);
                if (!anyWin && req[cand]) begin
                    anyWin = 1'b1;
                    winner = cand;
                end
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (anyWin && winner == TAG_W'(i)) begin
                gnt[i]  = 1'b1;
                winAddr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
        if (anyWin) begin
            rrPtr_d = (int'(winner) == NUM_REQ - 1) ? '0 : winner + TAG_W'(1);
        end
    end

    // Issue register: drive the DRAM read port one cycle after the grant and advance the pointer past the winner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rrPtr_q    <= '0;
            dramEn_q   <= 1'b0;
            dramAddr_q <= '0;
        end else begin
            rrPtr_q  <= rrPtr_d;
            dramEn_q <= anyWin;
            if (anyWin) begin
                dramAddr_q <= winAddr;
            end
        end
    end

    // Return register: route each returning word to the head tag; a return with nothing outstanding is a sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rspValid_q <= '0;
            rspData_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            rspValid_q <= doPop ? (NUM_REQ'(1) << headTag) : '0;
            if (doPop) begin
                rspData_q <= dram_data_rd;
            end
            if (dram_valid && fifoEmpty) begin
                err_q <= 1'b1;
            end
        end
    end

    dram_tag_fifo #(
        .DEPTH (MAX_OUT),
        .WIDTH (TAG_W),
        .CNT_W (CNT_W)
    ) u_tagFifo (
        .clk       (clk),
        .rst       (rst),
        .push_i    (anyWin),
        .pushTag_i (winner),
        .pop_i     (doPop),
        .headTag_o (headTag),
        .full_o    (fifoFull),
        .empty_o   (fifoEmpty),
        .count_o   (outCount)
    );

    assign dram_en_rd   = dramEn_q;
    assign dram_addr_rd = dramAddr_q;
    assign rsp_valid    = rspValid_q;
    assign rsp_data     = rspData_q;
    assign err          = err_q;
    assign busy         = (outCount != '0) | (|rspValid_q);

endmodule

// File: tb/tb_dram_rd_arbiter.sv
// Self-checking bench for dram_rd_arbiter: fixed-latency DRAM model, random requesters,
// a reference model of the arbitration rules and a response scoreboard.
module tb_dram_rd_arbiter;
    import dram_rd_arbiter_pkg::*;

    localparam int DW = DATA_WIDTH_DEF;
    localparam int AW = ADDR_WIDTH_DEF;
    localparam int NR = NUM_REQ_DEF;
    localparam int MO = MAX_OUT_DEF;

    logic             clk = 1'b0;
    logic             rst;
    logic [NR-1:0]    req;
    logic [NR*AW-1:0] req_addr;
    logic [NR-1:0]    gnt;
    logic [NR-1:0]    rsp_valid;
    logic [DW-1:0]    rsp_data;
    logic             dram_en_rd;
    logic [AW-1:0]    dram_addr_rd;
    logic             dram_valid;
    logic [DW-1:0]    dram_data_rd;
    logic             busy;
    logic             err;

    always #5 clk = ~clk;

    dram_rd_arbiter #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_REQ    (NR),
        .MAX_OUT    (MO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_addr     (req_addr),
        .gnt          (gnt),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .dram_en_rd   (dram_en_rd),
        .dram_addr_rd (dram_addr_rd),
        .dram_valid   (dram_valid),
        .dram_data_rd (dram_data_rd),
        .busy         (busy),
        .err          (err)
    );

    typedef struct {
        logic [AW-1:0] addr;
        int            due;
    } rd_t;

    typedef struct {
        int            id;
        logic [DW-1:0] data;
    } rsp_t;

    rd_t           dramQ[$];
    rsp_t          sbQ[$];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            lat = 2;
    int            reqProb[NR];
    logic          pend[NR];
    logic [AW-1:0] paddr[NR];
    int            modelCount;
    int            rrPtr;
    logic          expEn;
    logic [AW-1:0] expAddr;
    logic          expErr;
    logic          expRsp;
    logic          injectValid = 1'b0;
    logic [NR-1:0] lastGnt;
    int            gntTotal = 0;

    // Contents of the DRAM model: a fixed scramble of the address.
    function automatic logic [DW-1:0] memVal(input logic [AW-1:0] a);
        return (DW'(a) * 32'h0001_9E37) ^ 32'hA5A5_0F0F;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clearModel();
        dramQ.delete();
        sbQ.delete();
        for (int i = 0; i < NR; i++) begin
            pend[i]    = 1'b0;
            paddr[i]   = '0;
            reqProb[i] = 0;
        end
        modelCount = 0;
        rrPtr      = 0;
        expEn      = 1'b0;
        expAddr    = '0;
        expErr     = 1'b0;
        expRsp     = 1'b0;
    endtask

    // One clock cycle: check registered outputs, run the DRAM model, drive requests, check the grant, update the model.
    task automatic applyStimulus();
        int            win;
        logic          dv;
        logic          popNow;
        logic [DW-1:0] dd;
        rd_t           r;
        @(negedge clk);
        cyc++;
        checkOutput("dram_en_rd", dram_en_rd, expEn);
        checkOutput("dram_addr_rd", dram_addr_rd, expAddr);
        checkOutput("err", err, expErr);
        checkOutput("rsp_any", |rsp_valid, expRsp);
        checkOutput("busy", busy, (modelCount != 0) || expRsp);
        if (dram_en_rd) begin
            dramQ.push_back('{addr: dram_addr_rd, due: cyc + lat});
        end
        dv = 1'b0;
        dd = dram_data_rd;
        if (injectValid) begin
            dv          = 1'b1;
            dd          = $urandom;
            injectValid = 1'b0;
        end else if (dramQ.size() > 0 && dramQ[0].due <= cyc) begin
            r  = dramQ.pop_front();
            dv = 1'b1;
            dd = memVal(r.addr);
        end
        dram_valid   = dv;
        dram_data_rd = dd;
        for (int i = 0; i < NR; i++) begin
            if (!pend[i] && int'($urandom_range(99)) < reqProb[i]) begin
                pend[i]  = 1'b1;
                paddr[i] = AW'($urandom);
            end
        end
        for (int i = 0; i < NR; i++) begin
            req[i]                = pend[i];
            req_addr[i*AW +: AW]  = paddr[i];
        end
        #1;
        lastGnt = gnt;
        if (gnt != '0) gntTotal++;
        win = -1;
        if (modelCount < MO) begin
            for (int k = 0; k < NR; k++) begin
                int idx;
                idx = (rrPtr + k) % NR;
                if (win < 0 && pend[idx]) win = idx;
            end
        end
        checkOutput("gnt", gnt, (win >= 0) ? (64'd1 << win) : 64'd0);
        popNow = dv && (modelCount > 0);
        if (dv && modelCount == 0) expErr = 1'b1;
        expRsp = popNow;
        expEn  = (win >= 0);
        if (win >= 0) begin
            expAddr = paddr[win];
            sbQ.push_back('{id: win, data: memVal(paddr[win])});
            pend[win] = 1'b0;
            rrPtr     = (win + 1) % NR;
        end
        modelCount = modelCount + ((win >= 0) ? 1 : 0) - (popNow ? 1 : 0);
    endtask

    // Assert reset between edges; outputs must clear at once and grant must stay low with all requests high.
    task automatic applyReset();
        @(negedge clk);
        dram_valid  = 1'b0;
        injectValid = 1'b0;
        req         = '1;
        rst         = 1'b1;
        #1;
        checkOutput("reset_gnt", gnt, 0);
        checkOutput("reset_en", dram_en_rd, 0);
        checkOutput("reset_addr", dram_addr_rd, 0);
        checkOutput("reset_rsp_valid", rsp_valid, 0);
        checkOutput("reset_rsp_data", rsp_data, 0);
        checkOutput("reset_err", err, 0);
        checkOutput("reset_busy", busy, 0);
        clearModel();
        repeat (2) @(negedge clk);
        req = '0;
        rst = 1'b0;
    endtask

    // Stop new requests and run until every outstanding read has come back.
    task automatic drainAll();
        int guard;
        guard = 0;
        for (int i = 0; i < NR; i++) reqProb[i] = 0;
        while ((modelCount != 0 || expRsp || pend[0] || pend[1] || pend[2]) && guard < 400) begin
            applyStimulus();
            guard++;
        end
        checkOutput("drain_timeout", guard >= 400, 0);
        applyStimulus();
        checkOutput("idle_busy", busy, 0);
        checkOutput("idle_scoreboard", sbQ.size(), 0);
    endtask

    // Scoreboard monitor: every response strobe must match the oldest issued read.
    always @(negedge clk) begin
        rsp_t e;
        if (rst !== 1'b1 && rsp_valid != '0) begin
            if (sbQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL rsp_unexpected: got rsp_valid=%b expected none outstanding (cycle %0d)", rsp_valid, cyc);
            end else begin
                e = sbQ.pop_front();
                checkOutput("rsp_valid", rsp_valid, NR'(1) << e.id);
                checkOutput("rsp_data", rsp_data, e.data);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [NR-1:0] rotExp [6];
        rotExp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        rst          = 1'b1;
        req          = '0;
        req_addr     = '0;
        dram_valid   = 1'b0;
        dram_data_rd = '0;
        clearModel();
        applyReset();

        $display("[TB] single request from the weight loader");
        lat = 2;
        pend[int'(REQ_WGT)]  = 1'b1;
        paddr[int'(REQ_WGT)] = 18'h00100;
        applyStimulus();
        checkOutput("single_gnt", lastGnt, 3'b010);
        drainAll();

        $display("[TB] strict rotation with all requesters active");
        applyReset();
        for (int i = 0; i < NR; i++) reqProb[i] = 100;
        for (int n = 0; n < 6; n++) begin
            applyStimulus();
            checkOutput("rotation_gnt", lastGnt, rotExp[n]);
        end
        drainAll();

        $display("[TB] outstanding limit with long latency");
        applyReset();
        lat        = 10;
        reqProb[0] = 100;
        gntTotal   = 0;
        repeat (10) applyStimulus();
        checkOutput("full_grant_count", gntTotal, MO);
        repeat (20) applyStimulus();
        drainAll();

        $display("[TB] unsolicited return sets the error flag");
        lat         = 2;
        injectValid = 1'b1;
        applyStimulus();
        applyStimulus();
        checkOutput("err_sticky", err, 1);
        checkOutput("err_no_rsp", rsp_valid, 0);

        $display("[TB] reset with reads in flight");
        applyReset();
        lat = 10;
        for (int i = 0; i < NR; i++) begin
            pend[i]  = 1'b1;
            paddr[i] = AW'(18'h01000 + i);
        end
        repeat (5) applyStimulus();
        applyReset();
        pend[0]  = 1'b1;
        paddr[0] = 18'h02000;
        pend[2]  = 1'b1;
        paddr[2] = 18'h02002;
        applyStimulus();
        checkOutput("rr_after_reset", lastGnt, 3'b001);
        drainAll();

        $display("[TB] randomized traffic");
        for (int p = 0; p < 8; p++) begin
            lat = int'($urandom_range(1, 8));
            for (int i = 0; i < NR; i++) reqProb[i] = int'($urandom_range(0, 100));
            repeat (50) applyStimulus();
        end
        drainAll();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
